// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: per-key synchroniser, debounce FSM and
// registered press / release / auto-repeat step pulses.
module key_debounce_pulse #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] step_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    REL_WAIT
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic             s1;
    logic             s2;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    logic             pr;
    logic             rl;
    logic             st;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1    <= 1'b1;
        s2    <= 1'b1;
        state <= IDLE;
        cnt   <= '0;
        lvl   <= 1'b0;
        pr    <= 1'b0;
        rl    <= 1'b0;
        st    <= 1'b0;
      end else begin
        s1 <= key_n[i];
        s2 <= s1;
        pr <= 1'b0;
        rl <= 1'b0;
        st <= 1'b0;
        unique case (state)
          IDLE: begin
            if (!s2) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (s2) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state <= HELD;
              cnt   <= '0;
              lvl   <= 1'b1;
              pr    <= 1'b1;
              st    <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          HELD: begin
            if (s2) begin
              state <= REL_WAIT;
              cnt   <= '0;
            end else if (REPEAT_EN == 0) begin
              cnt <= '0;
            end else if (cnt == DLY_LAST) begin
              state <= REPEAT;
              cnt   <= '0;
              st    <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          REPEAT: begin
            if (s2) begin
              state <= REL_WAIT;
              cnt   <= '0;
            end else if (cnt == PER_LAST) begin
              cnt <= '0;
              st  <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          REL_WAIT: begin
            // a low sample here restarts the repeat delay from scratch
            if (!s2) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state <= IDLE;
              cnt   <= '0;
              lvl   <= 1'b0;
              rl    <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_level[i]     = lvl;
    assign press_pulse[i]   = pr;
    assign release_pulse[i] = rl;
    assign step_pulse[i]    = st;
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: directed scenarios plus random key
// activity, checked against a sample-history reference model.
module tb_key_debounce_pulse;

  localparam int NK  = 3;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] lvl1, pr1, rl1, st1;
  logic [NK-1:0] lvl0, pr0, rl0, st0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  key_debounce_pulse #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .key_level(lvl1), .press_pulse(pr1),
    .release_pulse(rl1), .step_pulse(st1)
  );

  key_debounce_pulse #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)
  ) dut_norep (
    .clk(clk), .rst(rst), .key_n(key_n),
    .key_level(lvl0), .press_pulse(pr0),
    .release_pulse(rl0), .step_pulse(st0)
  );

  logic [23:0] act;
  assign act = {lvl1, pr1, rl1, st1, lvl0, pr0, rl0, st0};

  // reference model state: raw and observed (post-synchroniser) histories
  logic [NK-1:0] rawq[$];
  logic [NK-1:0] obsq[$];
  logic [NK-1:0] m_level = '0;
  logic [NK-1:0] m_press, m_rel, m_step1, m_step0;
  int            anchor[NK];

  function automatic logic [23:0] exp_v();
    return {m_level, m_press, m_rel, m_step1,
            m_level, m_press, m_rel, m_step0};
  endfunction

  task automatic model_step();
    logic [NK-1:0] o;
    int  t;
    int  d;
    bit  flip;
    bit  held;
    m_press = '0;
    m_rel   = '0;
    m_step1 = '0;
    m_step0 = '0;
    if (rst) begin
      rawq.delete();
      obsq.delete();
      m_level = '0;
    end else begin
      rawq.push_back(key_n);
      o = (rawq.size() >= 3) ? rawq[rawq.size()-3] : '1;
      obsq.push_back(o);
      t = obsq.size() - 1;
      for (int i = 0; i < NK; i++) begin
        // level changes after DEB+1 consecutive opposite observations
        flip = (t >= DEB);
        for (int j = 0; j <= DEB && flip; j++)
          if (obsq[t-j][i] != m_level[i]) flip = 0;
        if (flip) begin
          if (!m_level[i]) begin
            m_level[i] = 1'b1;
            m_press[i] = 1'b1;
            m_step1[i] = 1'b1;
            m_step0[i] = 1'b1;
            anchor[i]  = t;
          end else begin
            m_level[i] = 1'b0;
            m_rel[i]   = 1'b1;
          end
        end else if (m_level[i]) begin
          if (t >= 1 && !o[i] && obsq[t-1][i]) anchor[i] = t;
          held = 1;
          for (int j = anchor[i]; j <= t; j++)
            if (obsq[j][i]) held = 0;
          d = t - anchor[i];
          if (held && d >= RD && ((d - RD) % RP) == 0)
            m_step1[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    key_n = '1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      key_n = 3'b000;
      cyc();
      vectors++;
      if (act !== exp_v()) begin
        miscompares++;
        $display("FAIL reset_pre k=%0d: got %h expected %h", k, act, exp_v());
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++;
      if (act !== 24'h0) begin
        miscompares++;
        $display("FAIL reset_clear k=%0d: got %h expected 000000", k, act);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_press_repeat();
    logic [31:0] pm = '0;
    logic [31:0] sm = '0;
    logic [31:0] lm = '0;
    logic [31:0] exp_sm = (32'd1 << 6) | (32'd1 << 16) | (32'd1 << 19);
    logic [31:0] exp_lm = 32'h000F_FFC0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      key_n = 3'b110;
      cyc();
      vectors++;
      if (act !== exp_v()) begin
        miscompares++;
        $display("FAIL press_repeat k=%0d: got %h expected %h", k, act, exp_v());
      end
      pm[k] = pr1[0];
      sm[k] = st1[0];
      lm[k] = lvl1[0];
    end
    vectors++;
    if (pm !== 32'h40) begin
      miscompares++;
      $display("FAIL press_edge: got %h expected %h", pm, 32'h40);
    end
    vectors++;
    if (sm !== exp_sm) begin
      miscompares++;
      $display("FAIL step_edges: got %h expected %h", sm, exp_sm);
    end
    vectors++;
    if (lm !== exp_lm) begin
      miscompares++;
      $display("FAIL level_rise: got %h expected %h", lm, exp_lm);
    end
  endtask

  task automatic test_bounce();
    bit seen = 0;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      key_n = (k < 9 && (k % 3) != 2) ? 3'b101 : 3'b111;
      cyc();
      vectors++;
      if (act !== exp_v()) begin
        miscompares++;
        $display("FAIL bounce k=%0d: got %h expected %h", k, act, exp_v());
      end
      if (lvl1[1] | pr1[1] | rl1[1] | st1[1]) seen = 1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_quiet: got %0d expected 0", seen);
    end
  endtask

  task automatic test_glitch_release();
    logic [63:0] rm = '0;
    logic        l38 = 1'b0;
    do_reset();
    for (int k = 0; k < 50; k++) begin
      key_n = (k < 30 || k == 32) ? 3'b110 : 3'b111;
      cyc();
      vectors++;
      if (act !== exp_v()) begin
        miscompares++;
        $display("FAIL glitch k=%0d: got %h expected %h", k, act, exp_v());
      end
      rm[k] = rl1[0];
      if (k == 38) l38 = lvl1[0];
    end
    vectors++;
    if (rm !== (64'd1 << 39)) begin
      miscompares++;
      $display("FAIL glitch_release: got %h expected %h", rm, 64'd1 << 39);
    end
    vectors++;
    if (l38 !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_level: got %b expected 1", l38);
    end
  endtask

  task automatic test_no_repeat();
    int np = 0;
    int ns = 0;
    int nr = 0;
    do_reset();
    for (int k = 0; k < 65; k++) begin
      key_n = (k < 50) ? 3'b011 : 3'b111;
      cyc();
      vectors++;
      if (act !== exp_v()) begin
        miscompares++;
        $display("FAIL norep k=%0d: got %h expected %h", k, act, exp_v());
      end
      np += int'(pr0[2]);
      ns += int'(st0[2]);
      nr += int'(rl0[2]);
    end
    vectors++;
    if (np != 1 || ns != 1 || nr != 1) begin
      miscompares++;
      $display("FAIL norep_counts: got p%0d s%0d r%0d expected p1 s1 r1",
               np, ns, nr);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] pv[10];
    do_reset();
    for (int k = 0; k < 10; k++) begin
      key_n = 3'b000;
      cyc();
      vectors++;
      if (act !== exp_v()) begin
        miscompares++;
        $display("FAIL simul k=%0d: got %h expected %h", k, act, exp_v());
      end
      pv[k] = pr1;
    end
    vectors++;
    if (pv[5] !== 3'b000 || pv[6] !== 3'b111 || pv[7] !== 3'b000) begin
      miscompares++;
      $display("FAIL simul_press: got %b/%b/%b expected 000/111/000",
               pv[5], pv[6], pv[7]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pm = '0;
    bit          lv = 0;
    logic [31:0] exp_pm = (32'd1 << 6) | (32'd1 << 26);
    do_reset();
    for (int k = 0; k < 30; k++) begin
      key_n = 3'b110;
      rst   = (k == 18 || k == 19);
      cyc();
      vectors++;
      if (act !== exp_v()) begin
        miscompares++;
        $display("FAIL rstmid k=%0d: got %h expected %h", k, act, exp_v());
      end
      pm[k] = pr1[0];
      if (k >= 18 && k <= 25 && lvl1[0]) lv = 1;
    end
    rst = 1'b0;
    vectors++;
    if (pm !== exp_pm) begin
      miscompares++;
      $display("FAIL rstmid_press: got %h expected %h", pm, exp_pm);
    end
    vectors++;
    if (lv !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_level: got %0d expected 0", lv);
    end
  endtask

  task automatic test_random();
    int            rem[NK];
    logic [NK-1:0] kv = '1;
    do_reset();
    for (int i = 0; i < NK; i++) rem[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (rem[i] == 0) begin
          kv[i]  = ~kv[i];
          rem[i] = ($urandom_range(0, 2) == 0) ?
                   int'($urandom_range(1, 3)) : int'($urandom_range(5, 25));
        end
        rem[i]--;
      end
      rst   = ($urandom_range(0, 299) == 0);
      key_n = kv;
      cyc();
      vectors++;
      if (act !== exp_v()) begin
        miscompares++;
        $display("FAIL random c=%0d: got %h expected %h", c, act, exp_v());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    key_n = '1;
    for (int i = 0; i < NK; i++) anchor[i] = 0;
    test_reset();
    test_press_repeat();
    test_bounce();
    test_glitch_release();
    test_no_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
